pipe_ctrl: RTL and testbench

- Pipeline control unit for the five-stage Y86-64 pipeline (F/D/E/M/W).
- Each cycle it generates the stall and bubble controls for every pipeline register and the condition-code write enable.
- It sequences three hazard types:
  - load-use hazards,
  - branch mispredicts,
  - `ret` hazards, using a registered bubble counter.
- An exception/halt FSM drains and freezes the pipeline.
- Saturating performance counters report stall and bubble activity.

---
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 five-stage pipeline control (stall/bubble, cc enable, halt FSM, perf counters)
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   D_icode                 icode held in D
//   d_srcA, d_srcB          decode source registers (0xF = none)
//   E_icode, E_dstM         icode and load destination held in E
//   e_Cnd                   branch condition from execute
//   m_stat, W_stat          status leaving memory / held in W
//   F_stall..W_stall        per-register stall and bubble controls
//   set_cc                  condition-code write enable
//   halted                  pipeline frozen
//   stall_cnt, bubble_cnt   saturating activity counters
module pipe_ctrl #(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [3:0] I_JXX = 4'h7, I_OPQ = 4'h6, I_MRMOVQ = 4'h5, I_RET = 4'h9, I_POPQ = 4'hB;
    localparam logic [3:0] S_AOK = 4'h1, R_NONE = 4'hF;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;
    state_t           r_state, w_state_nxt;
    logic [2:0]       r_ret_cnt, w_ret_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;
    logic             w_lu, w_mp, w_retD, w_ret_busy, w_m_exc, w_w_exc;
    assign w_lu       = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && E_dstM != R_NONE &&
                        (E_dstM == d_srcA || E_dstM == d_srcB);
    assign w_mp       = E_icode == I_JXX && !e_Cnd;
    assign w_retD     = D_icode == I_RET;
    assign w_ret_busy = r_ret_cnt != 3'd0;
    assign w_m_exc    = m_stat != S_AOK;
    assign w_w_exc    = W_stat != S_AOK;
    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    // Output decode; reset forces bubbles into D/E/M while it is asserted.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b0;
        set_cc   = 1'b0;
        halted   = 1'b0;
        if (reset) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else if (r_state == ST_HALTED) begin
            F_stall = 1'b1;
            D_stall = 1'b1;
            W_stall = 1'b1;
            halted  = 1'b1;
        end else if (r_state == ST_DRAIN) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            F_stall  = w_lu | w_retD | w_ret_busy;
            D_stall  = w_lu;
            // a load-use stall holds the ret in D instead of bubbling it
            D_bubble = w_mp | (!w_lu & (w_retD | w_ret_busy));
            E_bubble = w_mp | w_lu;
            M_bubble = w_m_exc | w_w_exc;
            set_cc   = E_icode == I_OPQ && !w_m_exc && !w_w_exc;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = 3'd0;
        if (r_state == ST_RUN) begin
            w_state_nxt = w_w_exc ? ST_HALTED : w_m_exc ? ST_DRAIN : ST_RUN;
            // accepted ret: this cycle is the first bubble, count the rest
            w_ret_nxt   = w_mp ? 3'd0 :
                          (w_retD && !w_lu && !w_ret_busy) ? 3'(RET_BUBBLES - 1) :
                          w_ret_busy ? r_ret_cnt - 3'd1 : 3'd0;
        end else if (r_state == ST_DRAIN) begin
            w_state_nxt = w_w_exc ? ST_HALTED : ST_DRAIN;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_RUN;
            r_ret_cnt    <= 3'd0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ret_cnt <= w_ret_nxt;
            if (r_state == ST_RUN && F_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (E_bubble && !(&r_bubble_cnt))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl with a behavioural reference model
module tb_pipe_ctrl;
    localparam int RB = 3;
    localparam int CW = 4;
    localparam int MAXC = (1 << CW) - 1;
    typedef struct {
        logic [7:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] bc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] D_icode = 4'h1, d_srcA = 4'hF, d_srcB = 4'hF, E_icode = 4'h1, E_dstM = 4'hF;
    logic e_Cnd = 1'b1;
    logic [3:0] m_stat = 4'h1, W_stat = 4'h1;
    logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
    logic [CW-1:0] stall_cnt, bubble_cnt;
    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    // model state: phase 0 = running, 1 = draining, 2 = frozen
    int m_phase = 0;
    int m_left = 0;
    int m_sc = 0;
    int m_bc = 0;
    pipe_ctrl #(.RET_BUBBLES(RB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .halted(halted),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );
    always #5 clk = ~clk;
    task automatic step(input logic rs, input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ei, input logic [3:0] ed, input logic c,
                        input logic [3:0] ms, input logic [3:0] ws);
        exp_t e;
        logic lu, mp, rd, fs, db, eb;
        @(posedge clk);
        #1;
        reset = rs; D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = ed;
        e_Cnd = c; m_stat = ms; W_stat = ws;
        cyc++;
        if (rs) begin
            e.ctl = 8'b0011_1000; e.sc = '0; e.bc = '0;
            m_phase = 0; m_left = 0; m_sc = 0; m_bc = 0;
        end else begin
            e.sc = CW'(m_sc); e.bc = CW'(m_bc);
            lu = (ei == 4'h5 || ei == 4'hB) && ed != 4'hF && (ed == sa || ed == sb);
            mp = ei == 4'h7 && !c;
            rd = di == 4'h9;
            if (m_phase == 2) begin
                e.ctl = 8'b1100_0101;
            end else if (m_phase == 1) begin
                e.ctl = 8'b1011_1000;
                m_bc = (m_bc < MAXC) ? m_bc + 1 : MAXC;
                m_left = 0;
                if (ws != 4'h1) m_phase = 2;
            end else begin
                fs = lu || rd || m_left > 0;
                db = mp || (!lu && (rd || m_left > 0));
                eb = mp || lu;
                e.ctl = {fs, lu, db, eb, ms != 4'h1 || ws != 4'h1, 1'b0,
                         ei == 4'h6 && ms == 4'h1 && ws == 4'h1, 1'b0};
                if (fs) m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
                if (eb) m_bc = (m_bc < MAXC) ? m_bc + 1 : MAXC;
                if (mp) m_left = 0;
                else if (rd && !lu && m_left == 0) m_left = RB - 1;
                else if (m_left > 0) m_left--;
                if (ws != 4'h1) m_phase = 2;
                else if (ms != 4'h1) m_phase = 1;
            end
        end
        q.push_back(e);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1);
    endtask
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};
            checks++;
            if (act !== e.ctl || stall_cnt !== e.sc || bubble_cnt !== e.bc) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t ctl[F,Ds,Db,Eb,Mb,Ws,cc,h]=%b exp=%b stall_cnt=%0d exp=%0d bubble_cnt=%0d exp=%0d",
                         $time, act, e.ctl, stall_cnt, e.sc, bubble_cnt, e.bc);
            end
        end
    end
    function automatic logic [3:0] rstat();
        int r = $urandom_range(0, 99);
        return (r < 94) ? 4'h1 : 4'($urandom_range(2, 4));
    endfunction
    function automatic logic [3:0] rreg();
        int r = $urandom_range(0, 4);
        return (r == 4) ? 4'hF : 4'(r);
    endfunction
    initial begin
        step(1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1);
        idle(2);
        // load-use for one cycle
        step(1'b0, 4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b1, 4'h1, 4'h1);
        idle(2);
        // ret: RB bubbles
        step(1'b0, 4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1);
        idle(RB + 2);
        // ret blocked by load-use, then accepted
        step(1'b0, 4'h9, 4'h2, 4'hF, 4'hB, 4'h2, 1'b1, 4'h1, 4'h1);
        step(1'b0, 4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1);
        idle(RB + 1);
        // mispredict during ret
        step(1'b0, 4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1);
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 4'h1);
        idle(2);
        // mispredict with load-use together is impossible by icode; OPQ sets cc
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h1, 4'h1);
        // exception drain then halt, held for 10 cycles
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b1, 4'h3, 4'h1);
        idle(2);
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h3);
        idle(10);
        // reset from halted
        step(1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1);
        step(1'b1, 4'h9, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h3, 4'h1);
        idle(1);
        // direct halt from run on W exception
        step(1'b0, 4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 4'h4);
        idle(2);
        step(1'b1, 4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b1, 4'h1, 4'h1);
        // saturation: hold load-use 20 cycles
        for (int i = 0; i < 20; i++) step(1'b0, 4'h1, 4'hF, 4'h4, 4'h5, 4'h4, 1'b1, 4'h1, 4'h1);
        idle(2);
        // randomized stress
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] ei, di;
            di = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
            case ($urandom_range(0, 3))
                0: ei = 4'h5;
                1: ei = 4'hB;
                2: ei = 4'h7;
                default: ei = 4'($urandom_range(0, 11));
            endcase
            step($urandom_range(0, 49) == 0, di, rreg(), rreg(), ei, rreg(), 1'($urandom_range(0, 1)),
                 rstat(), rstat());
        end
        idle(2);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
